// File: rtl/lsu_pkg.sv
// Shared encodings, size masks and FSM states for the load/store AGU.
package lsu_pkg;

   localparam int LSU_DW = 32;

   // funct3 size/sign encodings for loads and stores
   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   // Byte strobe masks for an access at byte offset 0
   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   typedef enum logic {
      LSU_IDLE   = 1'b0,
      LSU_SPLIT2 = 1'b1
   } lsu_state_e;

   // Maps funct3[1:0] to an unshifted strobe mask; 11 has no legal size
   function automatic logic [3:0] size_mask(input logic [1:0] size);
      case (size)
         2'b00:   size_mask = MASK_B;
         2'b01:   size_mask = MASK_H;
         2'b10:   size_mask = MASK_W;
         default: size_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/lsu_agu_if.sv
// Execute-stage request bus and memory-side request bus of the AGU.
// Handshake: a request is taken on a rising clock edge when ex_valid=1 and
// lsu_busy=0 (lsu_busy already folds in mem_stall); while lsu_busy=1 the
// upstream stage must keep its request, unchanged, on the bus.
interface lsu_agu_if #(parameter int DATA_WIDTH = lsu_pkg::LSU_DW);
   logic                    ex_valid;
   logic                    ex_load;
   logic                    ex_store;
   logic [2:0]              ex_funct3;
   logic [DATA_WIDTH-1:0]   ex_base;
   logic [DATA_WIDTH-1:0]   ex_offset;
   logic [DATA_WIDTH-1:0]   ex_store_data;
   logic                    mem_stall;

   logic                    wr_en;
   logic                    rd_en;
   logic [DATA_WIDTH-1:0]   wr_addr;
   logic [DATA_WIDTH-1:0]   rd_addr;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [DATA_WIDTH/8-1:0] byte_en;
   logic                    sign_bit;
   logic                    lsu_busy;
   logic                    misalign_exc;
   logic [DATA_WIDTH-1:0]   misalign_addr;
   logic                    illegal_exc;

   modport master (
      output ex_valid, ex_load, ex_store, ex_funct3, ex_base, ex_offset,
             ex_store_data, mem_stall,
      input  wr_en, rd_en, wr_addr, rd_addr, wr_data, byte_en, sign_bit,
             lsu_busy, misalign_exc, misalign_addr, illegal_exc
   );

   modport slave (
      input  ex_valid, ex_load, ex_store, ex_funct3, ex_base, ex_offset,
             ex_store_data, mem_stall,
      output wr_en, rd_en, wr_addr, rd_addr, wr_data, byte_en, sign_bit,
             lsu_busy, misalign_exc, misalign_addr, illegal_exc
   );
endinterface

// File: rtl/lsu_align.sv
// Combinational address/alignment datapath: effective address, strobes
// spanning two words, misalignment flags and both lane-shifted store words.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = LSU_DW
) (
   input  logic [DATA_WIDTH-1:0] base,
   input  logic [DATA_WIDTH-1:0] offset,
   input  logic [DATA_WIDTH-1:0] store_data,
   input  logic [1:0]            size,
   output logic [DATA_WIDTH-1:0] ea,
   output logic [DATA_WIDTH-1:0] word_addr,
   output logic [DATA_WIDTH-1:0] next_addr,
   output logic [DATA_WIDTH-1:0] data_lo,
   output logic [DATA_WIDTH-1:0] data_hi,
   output logic [7:0]            m8,
   output logic                  load_misalign,
   output logic                  cross_word
);

   logic [1:0] off;
   logic [3:0] mask;
   logic [5:0] hi_shift;

   // Address sum, strobe window over two words and the split data lanes
   always_comb begin
      ea        = base + offset;
      off       = ea[1:0];
      word_addr = {ea[DATA_WIDTH-1:2], 2'b00};
      next_addr = word_addr + DATA_WIDTH'(4);   // wraps at the top of memory
      mask      = size_mask(size);
      m8        = {4'b0000, mask} << off;
      cross_word = |m8[7:4];
      // Loads never split: halfwords need even, words need 4-byte alignment
      load_misalign = ((size == 2'b01) && off[0]) ||
                      ((size == 2'b10) && (off != 2'b00));
      data_lo  = store_data << {off, 3'b000};
      hi_shift = 6'd32 - {1'b0, off, 3'b000};
      data_hi  = store_data >> hi_shift;
   end

endmodule

// File: rtl/lsu_agu.sv
// Load/store address generation stage: registers one memory request per
// accepted op, splits word-crossing stores into two writes and raises
// misaligned-load / illegal-encoding exception pulses.
module lsu_agu
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = LSU_DW
) (
   input  logic       mem_clk,
   input  logic       mem_rst,
   lsu_agu_if.slave   bus,
   output lsu_state_e dbg_state
);

   localparam int BE_W = DATA_WIDTH / 8;

   lsu_state_e state_q, state_d;

   logic [DATA_WIDTH-1:0] ea, word_addr, next_addr, data_lo, data_hi;
   logic [7:0]            m8;
   logic                  load_misalign, cross_word;
   logic                  accept, illegal;

   logic                  wr_en_q, rd_en_q, sign_bit_q, misalign_q, illegal_q;
   logic [DATA_WIDTH-1:0] wr_addr_q, rd_addr_q, wr_data_q, misalign_addr_q;
   logic [BE_W-1:0]       byte_en_q;

   // Second half of a split store, captured when the store is accepted
   logic [DATA_WIDTH-1:0] hi_addr_q, hi_data_q;
   logic [BE_W-1:0]       hi_be_q;

   lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .base          (bus.ex_base),
      .offset        (bus.ex_offset),
      .store_data    (bus.ex_store_data),
      .size          (bus.ex_funct3[1:0]),
      .ea            (ea),
      .word_addr     (word_addr),
      .next_addr     (next_addr),
      .data_lo       (data_lo),
      .data_hi       (data_hi),
      .m8            (m8),
      .load_misalign (load_misalign),
      .cross_word    (cross_word)
   );

   assign bus.lsu_busy = (state_q == LSU_SPLIT2) | bus.mem_stall;
   assign accept       = bus.ex_valid & ~bus.lsu_busy;

   // Encodings that must not reach memory
   assign illegal = (bus.ex_load == bus.ex_store) ||
                    (bus.ex_load && ((bus.ex_funct3 == 3'b011) ||
                                     (bus.ex_funct3 == 3'b110) ||
                                     (bus.ex_funct3 == 3'b111))) ||
                    (bus.ex_store && bus.ex_funct3[2]);

   // FSM state register
   always_ff @(posedge mem_clk or negedge mem_rst) begin
      if (!mem_rst) state_q <= LSU_IDLE;
      else          state_q <= state_d;
   end

   // Next state: enter SPLIT2 on a word-crossing store, leave once unstalled
   always_comb begin
      state_d = state_q;
      case (state_q)
         LSU_IDLE:
            if (accept && !illegal && bus.ex_store && cross_word)
               state_d = LSU_SPLIT2;
         LSU_SPLIT2:
            if (!bus.mem_stall) state_d = LSU_IDLE;
         default: state_d = LSU_IDLE;
      endcase
   end

   // Output registers: pulses default low, addresses/data hold unless loaded
   always_ff @(posedge mem_clk or negedge mem_rst) begin
      if (!mem_rst) begin
         wr_en_q         <= 1'b0;
         rd_en_q         <= 1'b0;
         sign_bit_q      <= 1'b0;
         misalign_q      <= 1'b0;
         illegal_q       <= 1'b0;
         wr_addr_q       <= '0;
         rd_addr_q       <= '0;
         wr_data_q       <= '0;
         misalign_addr_q <= '0;
         byte_en_q       <= '0;
         hi_addr_q       <= '0;
         hi_data_q       <= '0;
         hi_be_q         <= '0;
      end else if (!bus.mem_stall) begin
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         misalign_q <= 1'b0;
         illegal_q  <= 1'b0;
         if (state_q == LSU_SPLIT2) begin
            wr_en_q    <= 1'b1;
            wr_addr_q  <= hi_addr_q;
            byte_en_q  <= hi_be_q;
            wr_data_q  <= hi_data_q;
            sign_bit_q <= 1'b0;
         end else if (accept) begin
            if (illegal) begin
               illegal_q <= 1'b1;
            end else if (bus.ex_load) begin
               if (load_misalign) begin
                  misalign_q      <= 1'b1;
                  misalign_addr_q <= ea;
               end else begin
                  rd_en_q    <= 1'b1;
                  rd_addr_q  <= word_addr;
                  byte_en_q  <= m8[3:0];
                  sign_bit_q <= ~bus.ex_funct3[2];
               end
            end else begin
               wr_en_q    <= 1'b1;
               wr_addr_q  <= word_addr;
               byte_en_q  <= m8[3:0];
               wr_data_q  <= data_lo;
               sign_bit_q <= 1'b0;
               hi_addr_q  <= next_addr;
               hi_be_q    <= m8[7:4];
               hi_data_q  <= data_hi;
            end
         end
      end
   end

   assign bus.wr_en         = wr_en_q;
   assign bus.rd_en         = rd_en_q;
   assign bus.wr_addr       = wr_addr_q;
   assign bus.rd_addr       = rd_addr_q;
   assign bus.wr_data       = wr_data_q;
   assign bus.byte_en       = byte_en_q;
   assign bus.sign_bit      = sign_bit_q;
   assign bus.misalign_exc  = misalign_q;
   assign bus.misalign_addr = misalign_addr_q;
   assign bus.illegal_exc   = illegal_q;
   assign dbg_state         = state_q;

endmodule

// File: tb/tb_lsu_agu.sv
// Directed bench for lsu_agu: hand-computed expectations per scenario.
module tb_lsu_agu;
   import lsu_pkg::*;

   logic       mem_clk;
   logic       mem_rst;
   lsu_state_e dbg_state;
   int         total;
   int         bad;

   lsu_agu_if bus ();

   lsu_agu dut (
      .mem_clk   (mem_clk),
      .mem_rst   (mem_rst),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   // Clock
   initial mem_clk = 1'b0;
   always #5 mem_clk = ~mem_clk;

   // Driver: present one request for one edge, then drop ex_valid
   task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] base, input logic [31:0] off,
                        input logic [31:0] data);
      bus.ex_valid      = 1'b1;
      bus.ex_load       = ld;
      bus.ex_store      = st;
      bus.ex_funct3     = f3;
      bus.ex_base       = base;
      bus.ex_offset     = off;
      bus.ex_store_data = data;
      @(posedge mem_clk); #1;
      bus.ex_valid = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge mem_clk); #1;
   endtask

   task automatic test_reset();
      mem_rst = 1'b1;
      #3 mem_rst = 1'b0;
      @(posedge mem_clk); @(posedge mem_clk); #1;
      total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%0h exp=0", bus.wr_en); end
      total++; if (bus.rd_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en got=%0h exp=0", bus.rd_en); end
      total++; if (bus.wr_addr !== 32'h0) begin bad++; $display("FAIL rst_wr_addr got=%h exp=0", bus.wr_addr); end
      total++; if (bus.byte_en !== 4'h0) begin bad++; $display("FAIL rst_byte_en got=%h exp=0", bus.byte_en); end
      total++; if (bus.misalign_exc !== 1'b0 || bus.illegal_exc !== 1'b0) begin bad++; $display("FAIL rst_exc got=%b%b exp=00", bus.misalign_exc, bus.illegal_exc); end
      total++; if (bus.lsu_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", bus.lsu_busy); end
      total++; if (dbg_state !== LSU_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, LSU_IDLE); end
      #2 mem_rst = 1'b1;
      idle_cycle();
   endtask

   task automatic test_sw();
      issue(1'b0, 1'b1, LSU_W, 32'h100, 32'h4, 32'hDEADBEEF);
      total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL sw_wr_en got=%0h exp=1", bus.wr_en); end
      total++; if (bus.wr_addr !== 32'h104) begin bad++; $display("FAIL sw_wr_addr got=%h exp=00000104", bus.wr_addr); end
      total++; if (bus.byte_en !== 4'b1111) begin bad++; $display("FAIL sw_byte_en got=%b exp=1111", bus.byte_en); end
      total++; if (bus.wr_data !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wr_data got=%h exp=deadbeef", bus.wr_data); end
      total++; if (bus.lsu_busy !== 1'b0) begin bad++; $display("FAIL sw_busy got=%0h exp=0", bus.lsu_busy); end
      total++; if (bus.rd_en !== 1'b0) begin bad++; $display("FAIL sw_rd_en got=%0h exp=0", bus.rd_en); end
      idle_cycle();
      total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL sw_idle_wr_en got=%0h exp=0", bus.wr_en); end
      total++; if (bus.wr_addr !== 32'h104) begin bad++; $display("FAIL sw_idle_hold got=%h exp=00000104", bus.wr_addr); end
   endtask

   task automatic test_sb_lhu();
      issue(1'b0, 1'b1, LSU_B, 32'h100, 32'h3, 32'h000000AB);
      total++; if (bus.wr_addr !== 32'h100) begin bad++; $display("FAIL sb_wr_addr got=%h exp=00000100", bus.wr_addr); end
      total++; if (bus.byte_en !== 4'b1000) begin bad++; $display("FAIL sb_byte_en got=%b exp=1000", bus.byte_en); end
      total++; if (bus.wr_data !== 32'hAB000000) begin bad++; $display("FAIL sb_wr_data got=%h exp=ab000000", bus.wr_data); end
      total++; if (bus.lsu_busy !== 1'b0) begin bad++; $display("FAIL sb_busy got=%0h exp=0", bus.lsu_busy); end
      issue(1'b1, 1'b0, LSU_HU, 32'h200, 32'h2, 32'h0);
      total++; if (bus.rd_en !== 1'b1 || bus.wr_en !== 1'b0) begin bad++; $display("FAIL lhu_en got=rd%0h wr%0h exp=rd1 wr0", bus.rd_en, bus.wr_en); end
      total++; if (bus.rd_addr !== 32'h200) begin bad++; $display("FAIL lhu_rd_addr got=%h exp=00000200", bus.rd_addr); end
      total++; if (bus.byte_en !== 4'b1100) begin bad++; $display("FAIL lhu_byte_en got=%b exp=1100", bus.byte_en); end
      total++; if (bus.sign_bit !== 1'b0) begin bad++; $display("FAIL lhu_sign got=%0h exp=0", bus.sign_bit); end
      // lb with negative offset: 0x300 + (-1) = 0x2FF
      issue(1'b1, 1'b0, LSU_B, 32'h300, 32'hFFFFFFFF, 32'h0);
      total++; if (bus.rd_addr !== 32'h2FC) begin bad++; $display("FAIL lb_rd_addr got=%h exp=000002fc", bus.rd_addr); end
      total++; if (bus.byte_en !== 4'b1000) begin bad++; $display("FAIL lb_byte_en got=%b exp=1000", bus.byte_en); end
      total++; if (bus.sign_bit !== 1'b1) begin bad++; $display("FAIL lb_sign got=%0h exp=1", bus.sign_bit); end
      idle_cycle();
      total++; if (bus.rd_en !== 1'b0) begin bad++; $display("FAIL ld_idle_rd_en got=%0h exp=0", bus.rd_en); end
   endtask

   task automatic test_split();
      issue(1'b0, 1'b1, LSU_W, 32'h100, 32'h1, 32'h11223344);
      total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL split1_wr_en got=%0h exp=1", bus.wr_en); end
      total++; if (bus.wr_addr !== 32'h100) begin bad++; $display("FAIL split1_wr_addr got=%h exp=00000100", bus.wr_addr); end
      total++; if (bus.byte_en !== 4'b1110) begin bad++; $display("FAIL split1_byte_en got=%b exp=1110", bus.byte_en); end
      total++; if (bus.wr_data !== 32'h22334400) begin bad++; $display("FAIL split1_wr_data got=%h exp=22334400", bus.wr_data); end
      total++; if (bus.lsu_busy !== 1'b1) begin bad++; $display("FAIL split_busy got=%0h exp=1", bus.lsu_busy); end
      total++; if (dbg_state !== LSU_SPLIT2) begin bad++; $display("FAIL split_state got=%0d exp=%0d", dbg_state, LSU_SPLIT2); end
      // Next request held on the bus while busy: sb 0x55 to 0x400
      bus.ex_valid = 1'b1; bus.ex_load = 1'b0; bus.ex_store = 1'b1; bus.ex_funct3 = LSU_B;
      bus.ex_base = 32'h400; bus.ex_offset = 32'h0; bus.ex_store_data = 32'h00000055;
      @(posedge mem_clk); #1;
      total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL split2_wr_en got=%0h exp=1", bus.wr_en); end
      total++; if (bus.wr_addr !== 32'h104) begin bad++; $display("FAIL split2_wr_addr got=%h exp=00000104", bus.wr_addr); end
      total++; if (bus.byte_en !== 4'b0001) begin bad++; $display("FAIL split2_byte_en got=%b exp=0001", bus.byte_en); end
      total++; if (bus.wr_data !== 32'h00000011) begin bad++; $display("FAIL split2_wr_data got=%h exp=00000011", bus.wr_data); end
      @(posedge mem_clk); #1;
      bus.ex_valid = 1'b0;
      total++; if (bus.wr_addr !== 32'h400 || bus.wr_en !== 1'b1) begin bad++; $display("FAIL held_req got=%h/%0h exp=00000400/1", bus.wr_addr, bus.wr_en); end
      total++; if (bus.byte_en !== 4'b0001 || bus.wr_data !== 32'h55) begin bad++; $display("FAIL held_req_data got=%b/%h exp=0001/00000055", bus.byte_en, bus.wr_data); end
      idle_cycle();
   endtask

   task automatic test_exc();
      issue(1'b1, 1'b0, LSU_W, 32'h100, 32'h2, 32'h0);
      total++; if (bus.misalign_exc !== 1'b1) begin bad++; $display("FAIL lw_mis_exc got=%0h exp=1", bus.misalign_exc); end
      total++; if (bus.misalign_addr !== 32'h102) begin bad++; $display("FAIL lw_mis_addr got=%h exp=00000102", bus.misalign_addr); end
      total++; if (bus.rd_en !== 1'b0) begin bad++; $display("FAIL lw_mis_rd_en got=%0h exp=0", bus.rd_en); end
      idle_cycle();
      total++; if (bus.misalign_exc !== 1'b0) begin bad++; $display("FAIL lw_mis_pulse got=%0h exp=0", bus.misalign_exc); end
      issue(1'b1, 1'b0, LSU_H, 32'h201, 32'h0, 32'h0);
      total++; if (bus.misalign_exc !== 1'b1 || bus.misalign_addr !== 32'h201) begin bad++; $display("FAIL lh_mis got=%0h/%h exp=1/00000201", bus.misalign_exc, bus.misalign_addr); end
      issue(1'b1, 1'b0, LSU_BU, 32'h203, 32'h0, 32'h0);
      total++; if (bus.misalign_exc !== 1'b0 || bus.rd_en !== 1'b1) begin bad++; $display("FAIL lbu_ok got=mis%0h rd%0h exp=mis0 rd1", bus.misalign_exc, bus.rd_en); end
      issue(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0);
      total++; if (bus.illegal_exc !== 1'b1) begin bad++; $display("FAIL ill_f3_exc got=%0h exp=1", bus.illegal_exc); end
      total++; if (bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0) begin bad++; $display("FAIL ill_f3_access got=rd%0h wr%0h exp=0", bus.rd_en, bus.wr_en); end
      issue(1'b1, 1'b1, LSU_W, 32'h100, 32'h0, 32'h0);
      total++; if (bus.illegal_exc !== 1'b1 || bus.wr_en !== 1'b0) begin bad++; $display("FAIL ill_both got=%0h/%0h exp=1/0", bus.illegal_exc, bus.wr_en); end
      issue(1'b0, 1'b0, LSU_W, 32'h100, 32'h0, 32'h0);
      total++; if (bus.illegal_exc !== 1'b1 || bus.rd_en !== 1'b0) begin bad++; $display("FAIL ill_none got=%0h/%0h exp=1/0", bus.illegal_exc, bus.rd_en); end
      issue(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 32'h0);
      total++; if (bus.illegal_exc !== 1'b1 || bus.wr_en !== 1'b0) begin bad++; $display("FAIL ill_st_f3 got=%0h/%0h exp=1/0", bus.illegal_exc, bus.wr_en); end
      idle_cycle();
      total++; if (bus.illegal_exc !== 1'b0) begin bad++; $display("FAIL ill_pulse got=%0h exp=0", bus.illegal_exc); end
   endtask

   task automatic test_stall_wrap();
      int extra;
      issue(1'b0, 1'b1, LSU_H, 32'hFFFFFFFF, 32'h0, 32'h0000BEEF);
      total++; if (bus.wr_addr !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap1_wr_addr got=%h exp=fffffffc", bus.wr_addr); end
      total++; if (bus.byte_en !== 4'b1000) begin bad++; $display("FAIL wrap1_byte_en got=%b exp=1000", bus.byte_en); end
      total++; if (bus.wr_data !== 32'hEF000000) begin bad++; $display("FAIL wrap1_wr_data got=%h exp=ef000000", bus.wr_data); end
      bus.mem_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge mem_clk); #1;
         total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 32'hFFFFFFFC || bus.byte_en !== 4'b1000) begin bad++; $display("FAIL stall_frozen%0d got=%0h/%h/%b exp=1/fffffffc/1000", i, bus.wr_en, bus.wr_addr, bus.byte_en); end
         total++; if (dbg_state !== LSU_SPLIT2 || bus.lsu_busy !== 1'b1) begin bad++; $display("FAIL stall_state%0d got=%0d/%0h exp=%0d/1", i, dbg_state, bus.lsu_busy, LSU_SPLIT2); end
      end
      bus.mem_stall = 1'b0;
      @(posedge mem_clk); #1;
      total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 32'h0) begin bad++; $display("FAIL wrap2_wr_addr got=%0h/%h exp=1/00000000", bus.wr_en, bus.wr_addr); end
      total++; if (bus.byte_en !== 4'b0001) begin bad++; $display("FAIL wrap2_byte_en got=%b exp=0001", bus.byte_en); end
      total++; if (bus.wr_data !== 32'h000000BE) begin bad++; $display("FAIL wrap2_wr_data got=%h exp=000000be", bus.wr_data); end
      extra = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge mem_clk); #1;
         if (bus.wr_en === 1'b1) extra++;
      end
      total++; if (extra !== 0) begin bad++; $display("FAIL wrap_extra_writes got=%0d exp=0", extra); end
   endtask

   task automatic test_stall_exc();
      issue(1'b1, 1'b0, LSU_W, 32'h200, 32'h1, 32'h0);
      bus.mem_stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge mem_clk); #1;
         total++; if (bus.misalign_exc !== 1'b1 || bus.misalign_addr !== 32'h201) begin bad++; $display("FAIL stall_exc_hold%0d got=%0h/%h exp=1/00000201", i, bus.misalign_exc, bus.misalign_addr); end
      end
      bus.mem_stall = 1'b0;
      @(posedge mem_clk); #1;
      total++; if (bus.misalign_exc !== 1'b0) begin bad++; $display("FAIL stall_exc_release got=%0h exp=0", bus.misalign_exc); end
   endtask

   task automatic test_reset_mid_split();
      int writes;
      issue(1'b0, 1'b1, LSU_W, 32'h100, 32'h2, 32'hAABBCCDD);
      total++; if (dbg_state !== LSU_SPLIT2) begin bad++; $display("FAIL mid_pre_state got=%0d exp=%0d", dbg_state, LSU_SPLIT2); end
      #2 mem_rst = 1'b0;
      #1;
      total++; if (bus.wr_en !== 1'b0 || bus.wr_addr !== 32'h0 || bus.wr_data !== 32'h0 || bus.byte_en !== 4'h0) begin bad++; $display("FAIL mid_rst_outputs got=%0h/%h/%h/%b exp=0", bus.wr_en, bus.wr_addr, bus.wr_data, bus.byte_en); end
      total++; if (dbg_state !== LSU_IDLE || bus.lsu_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_state got=%0d/%0h exp=%0d/0", dbg_state, bus.lsu_busy, LSU_IDLE); end
      @(posedge mem_clk); #2;
      mem_rst = 1'b1;
      writes = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge mem_clk); #1;
         if (bus.wr_en === 1'b1) writes++;
      end
      total++; if (writes !== 0) begin bad++; $display("FAIL mid_rst_second_half got=%0d exp=0", writes); end
      total++; if (dbg_state !== LSU_IDLE || bus.wr_addr !== 32'h0) begin bad++; $display("FAIL mid_rst_after got=%0d/%h exp=%0d/00000000", dbg_state, bus.wr_addr, LSU_IDLE); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      mem_rst           = 1'b1;
      bus.ex_valid      = 1'b0;
      bus.ex_load       = 1'b0;
      bus.ex_store      = 1'b0;
      bus.ex_funct3     = 3'b000;
      bus.ex_base       = 32'h0;
      bus.ex_offset     = 32'h0;
      bus.ex_store_data = 32'h0;
      bus.mem_stall     = 1'b0;
      test_reset();
      test_sw();
      test_sb_lhu();
      test_split();
      test_exc();
      test_stall_wrap();
      test_stall_exc();
      test_reset_mid_split();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
